// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access / write-back pipeline stage
//
// Purpose:
//   Sits directly after the execute stage. ALU/MOV results go straight to the
//   register-file write port one cycle after the handshake. Word loads and
//   stores run over a req/ack data-memory bus. A request that waits too long
//   for an ack is aborted with a fault pulse. EX is back-pressured through
//   ex_ready for as long as a memory access is outstanding.
//
// Parameters:
//   ADDR_W   data-memory word-address width
//   TIMEOUT  max cycles mem_req stays high without mem_ack (>= 2)
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   ex_valid / ex_ready       EX handshake; transfer when both are high
//   ex_result[32:0]           data or byte address ([32] carry, unused here)
//   ex_w_enable, ex_dest_reg  register write request and destination index
//   ex_is_load, ex_is_store   memory operation selectors
//   ex_store_data             store data
//   mem_req/mem_we/mem_addr/mem_wdata   data-memory request (registered)
//   mem_rdata, mem_ack        data-memory response
//   wb_enable/wb_reg/wb_data  register-file write port (registered)
//   mem_fault                 one-cycle pulse on misaligned/illegal/timeout

module mem_wb_stage #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [32:0]       ex_result,
  input  logic              ex_w_enable,
  input  logic [2:0]        ex_dest_reg,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [31:0]       ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_enable,
  output logic [2:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic              mem_fault
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_END = CW'(TIMEOUT - 1);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_is_load;
  logic [2:0]        r_dest;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_wb_enable;
  logic [2:0]        r_wb_reg;
  logic [31:0]       r_wb_data;
  logic              r_mem_fault;

  logic w_xfer;
  logic w_is_mem;
  logic w_illegal;
  logic w_misaligned;
  logic w_unused_bits;

  assign w_xfer       = ex_valid && (r_state == S_IDLE);
  assign w_is_mem     = ex_is_load ^ ex_is_store;
  assign w_illegal    = ex_is_load && ex_is_store;
  assign w_misaligned = (ex_result[1:0] != 2'b00);

  // Carry and the address bits above the word-address window are not used.
  assign w_unused_bits = ^{ex_result[32:ADDR_W+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_is_load   <= 1'b0;
      r_dest      <= 3'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_wb_enable <= 1'b0;
      r_wb_reg    <= 3'd0;
      r_wb_data   <= 32'd0;
      r_mem_fault <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_wb_enable <= 1'b0;
      r_mem_fault <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_illegal || (w_is_mem && w_misaligned)) begin
              r_mem_fault <= 1'b1;
            end else if (w_is_mem) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= ex_is_store;
              r_mem_addr  <= ex_result[ADDR_W+1:2];
              r_mem_wdata <= ex_store_data;
              r_dest      <= ex_dest_reg;
              r_is_load   <= ex_is_load;
              r_wait_cnt  <= '0;
              r_state     <= S_ACCESS;
            end else begin
              r_wb_enable <= ex_w_enable;
              r_wb_reg    <= ex_dest_reg;
              r_wb_data   <= ex_result[31:0];
            end
          end
        end

        S_ACCESS: begin
          // Ack is checked first so an ack on the final count still completes.
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
            if (r_is_load) begin
              r_wb_enable <= 1'b1;
              r_wb_reg    <= r_dest;
              r_wb_data   <= mem_rdata;
            end
          end else if (r_wait_cnt == CNT_END) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_fault <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ex_ready  = (r_state == S_IDLE);
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_enable = r_wb_enable;
  assign wb_reg    = r_wb_reg;
  assign wb_data   = r_wb_data;
  assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [32:0]       ex_result;
  logic              ex_w_enable;
  logic [2:0]        ex_dest_reg;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [31:0]       ex_store_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              wb_enable;
  logic [2:0]        wb_reg;
  logic [31:0]       wb_data;
  logic              mem_fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_model [0:15];

  mem_wb_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_w_enable(ex_w_enable), .ex_dest_reg(ex_dest_reg),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_store_data(ex_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  // Presents one instruction for exactly one transfer edge; returns just after it.
  task automatic drive_xfer(input logic ld, input logic st, input logic [31:0] res,
                            input logic [31:0] sdata, input logic wen, input logic [2:0] dst);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_result = {1'b1, res}; ex_store_data = sdata;
    ex_w_enable = wen; ex_dest_reg = dst;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ex_ready, mem_req, mem_we, wb_enable, mem_fault} !== 5'b10000 ||
        mem_addr !== '0 || mem_wdata !== 32'd0 || wb_reg !== 3'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset: rdy=%b req=%b we=%b wbe=%b flt=%b addr=%h wdata=%h reg=%0d data=%h, required rdy=1 others 0",
               ex_ready, mem_req, mem_we, wb_enable, mem_fault, mem_addr, mem_wdata, wb_reg, wb_data);
    end
  endtask

  task automatic test_alu;
    drive_xfer(1'b0, 1'b0, 32'h0000_1234, 32'd0, 1'b1, 3'd3);
    @(negedge clk);
    checks++;
    if (wb_enable !== 1'b1 || wb_reg !== 3'd3 || wb_data !== 32'h1234 ||
        ex_ready !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL alu: wbe=%b reg=%0d data=%h rdy=%b req=%b, required 1 3 00001234 1 0",
               wb_enable, wb_reg, wb_data, ex_ready, mem_req);
    end
    @(negedge clk);
    checks++;
    if (wb_enable !== 1'b0) begin
      failures++;
      $display("FAIL alu_pulse: wbe=%b, required 0", wb_enable);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [0:3];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_w_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex_result = {1'b0, vals[i]}; ex_dest_reg = 3'(i + 1);
      @(posedge clk); #1;
      checks++;
      if (wb_enable !== 1'b1 || wb_reg !== 3'(i + 1) || wb_data !== vals[i] || ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: wbe=%b reg=%0d data=%h rdy=%b, required 1 %0d %h 1",
                 i, wb_enable, wb_reg, wb_data, ex_ready, i + 1, vals[i]);
      end
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_load;
    drive_xfer(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 3'd5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h4 ||
          ex_ready !== 1'b0 || wb_enable !== 1'b0) begin
        failures++;
        $display("FAIL load_req[%0d]: req=%b we=%b addr=%h rdy=%b wbe=%b, required 1 0 0004 0 0",
                 c, mem_req, mem_we, mem_addr, ex_ready, wb_enable);
      end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (wb_enable !== 1'b1 || wb_reg !== 3'd5 || wb_data !== 32'hDEAD_BEEF ||
        mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_wb: wbe=%b reg=%0d data=%h req=%b rdy=%b, required 1 5 deadbeef 0 1",
               wb_enable, wb_reg, wb_data, mem_req, ex_ready);
    end
  endtask

  task automatic test_store;
    drive_xfer(1'b0, 1'b1, 32'h8, 32'hA5A5_A5A5, 1'b0, 3'd1);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h2 || mem_wdata !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h, required 1 1 0002 a5a5a5a5",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_enable !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1 || mem_fault !== 1'b0) begin
      failures++;
      $display("FAIL store_done: wbe=%b req=%b rdy=%b flt=%b, required 0 0 1 0",
               wb_enable, mem_req, ex_ready, mem_fault);
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    int faults = 0;
    int wbs = 0;
    drive_xfer(1'b1, 1'b0, 32'h20, 32'd0, 1'b1, 3'd2);
    for (int c = 0; c < TIMEOUT + 6; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) req_cycles++;
      if (mem_fault === 1'b1) faults++;
      if (wb_enable === 1'b1) wbs++;
      @(posedge clk); #1;
    end
    checks++;
    if (req_cycles != TIMEOUT || faults != 1 || wbs != 0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout: req_cycles=%0d faults=%0d wbs=%0d rdy=%b, required %0d 1 0 1",
               req_cycles, faults, wbs, ex_ready, TIMEOUT);
    end
  endtask

  task automatic test_faults;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive_xfer(1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 3'd4);
      else        drive_xfer(1'b1, 1'b1, 32'h14, 32'd0, 1'b1, 3'd4);
      @(negedge clk);
      checks++;
      if (mem_fault !== 1'b1 || mem_req !== 1'b0 || wb_enable !== 1'b0 || ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL fault[%0d]: flt=%b req=%b wbe=%b rdy=%b, required 1 0 0 1",
                 k, mem_fault, mem_req, wb_enable, ex_ready);
      end
      @(negedge clk);
      checks++;
      if (mem_fault !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL fault_pulse[%0d]: flt=%b req=%b, required 0 0", k, mem_fault, mem_req);
      end
    end
  endtask

  task automatic test_ack_in_idle;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_enable !== 1'b0 || mem_fault !== 1'b0 || mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL ack_idle: wbe=%b flt=%b req=%b rdy=%b, required 0 0 0 1",
               wb_enable, mem_fault, mem_req, ex_ready);
    end
  endtask

  task automatic test_reset_mid_access;
    int wbs = 0;
    drive_xfer(1'b1, 1'b0, 32'h4, 32'd0, 1'b1, 3'd6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: req=%b rdy=%b, required 0 1", mem_req, ex_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wb_enable === 1'b1 || mem_req === 1'b1) wbs++;
    end
    checks++;
    if (wbs != 0 || ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_after: stray_cycles=%0d rdy=%b, required 0 1", wbs, ex_ready);
    end
  endtask

  // Randomized mix of operations against a transaction-level memory model.
  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int op;
      int idx;
      int delay;
      logic [31:0] res;
      logic [31:0] sdata;
      logic [2:0]  dst;
      logic        wen;
      logic        done;
      op    = int'($urandom_range(0, 4));
      idx   = int'($urandom_range(0, 15));
      delay = int'($urandom_range(0, TIMEOUT + 1));
      sdata = $urandom;
      dst   = 3'($urandom);
      wen   = 1'($urandom);
      res   = (op == 0) ? $urandom : 32'(idx * 4);
      if (op == 3) res = res + 32'($urandom_range(1, 3));

      checks++;
      if (ex_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: rdy=%b, required 1", n, ex_ready);
      end
      case (op)
        0: drive_xfer(1'b0, 1'b0, res, sdata, wen, dst);
        1: drive_xfer(1'b1, 1'b0, res, sdata, wen, dst);
        2: drive_xfer(1'b0, 1'b1, res, sdata, wen, dst);
        3: drive_xfer(1'($urandom), 1'b1, res, sdata, wen, dst);
        default: drive_xfer(1'b1, 1'b1, res, sdata, wen, dst);
      endcase
      // op 3 with load=0 is a misaligned store; with load=1 it is illegal either way.

      if (op == 0) begin
        @(negedge clk);
        checks++;
        if (wb_enable !== wen || wb_reg !== dst || wb_data !== res || mem_req !== 1'b0) begin
          failures++;
          $display("FAIL rnd_alu[%0d]: wbe=%b reg=%0d data=%h req=%b, required %b %0d %h 0",
                   n, wb_enable, wb_reg, wb_data, mem_req, wen, dst, res);
        end
      end else if (op >= 3) begin
        @(negedge clk);
        checks++;
        if (mem_fault !== 1'b1 || mem_req !== 1'b0 || wb_enable !== 1'b0) begin
          failures++;
          $display("FAIL rnd_fault[%0d]: flt=%b req=%b wbe=%b, required 1 0 0",
                   n, mem_fault, mem_req, wb_enable);
        end
      end else begin
        done = 1'b0;
        for (int c = 0; c < TIMEOUT && !done; c++) begin
          @(negedge clk);
          checks++;
          if (mem_req !== 1'b1 || mem_we !== (op == 2) || mem_addr !== 16'(idx) ||
              (op == 2 && mem_wdata !== sdata) || ex_ready !== 1'b0) begin
            failures++;
            $display("FAIL rnd_req[%0d.%0d]: req=%b we=%b addr=%h wdata=%h rdy=%b, required 1 %b %h %h 0",
                     n, c, mem_req, mem_we, mem_addr, mem_wdata, ex_ready, op == 2, 16'(idx), sdata);
          end
          if (c == delay) begin
            mem_ack = 1'b1; mem_rdata = mem_model[idx];
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || wb_enable !== (op == 1) || mem_fault !== 1'b0 ||
                (op == 1 && (wb_reg !== dst || wb_data !== mem_model[idx]))) begin
              failures++;
              $display("FAIL rnd_done[%0d]: req=%b wbe=%b flt=%b reg=%0d data=%h, required 0 %b 0 %0d %h",
                       n, mem_req, wb_enable, mem_fault, wb_reg, wb_data, op == 1, dst, mem_model[idx]);
            end
            if (op == 2) mem_model[idx] = sdata;
            done = 1'b1;
          end else begin
            @(posedge clk); #1;
          end
        end
        if (!done) begin
          @(negedge clk);
          checks++;
          if (mem_req !== 1'b0 || mem_fault !== 1'b1 || wb_enable !== 1'b0) begin
            failures++;
            $display("FAIL rnd_timeout[%0d]: req=%b flt=%b wbe=%b, required 0 1 0",
                     n, mem_req, mem_fault, wb_enable);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (wb_enable !== 1'b0 || mem_fault !== 1'b0 || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL rnd_idle[%0d]: wbe=%b flt=%b req=%b, required 0 0 0",
                 n, wb_enable, mem_fault, mem_req);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_result = '0; ex_w_enable = 1'b0; ex_dest_reg = 3'd0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_store_data = 32'd0;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    test_reset;
    test_alu;
    test_back_to_back;
    test_load;
    test_store;
    test_timeout;
    test_faults;
    test_ack_in_idle;
    test_reset_mid_access;
    test_random;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
